mcpu_regfile_sb: RTL and testbench

//  Parametrised, clocked successor of the MCPU register file: 3 combinational read ports (RegOp1/alu1/alu2),
//  an execute write-back port (normal / internal MOV / load / nop) and a separate load-return port.

---
 rtl/mcpu_regfile_sb.sv | 170 +++++++++++++++++
 tb/tb_mcpu_regfile_sb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : mcpu_regfile_sb
//  Purpose  : MCPU register file with three combinational read ports, an
//             execute write-back port, a load-return port, optional
//             same-cycle bypass, optional hardwired-zero R0 and a per-register
//             scoreboard of outstanding loads for RAW hazard stalls.
//  Ports    : clk/rst          clock, synchronous active-high reset
//             op1/op2/op3      read addresses -> RegOp1/alu1/alu2
//             rd_use           per-port "operand consumed" (hazard check only)
//             wb_*             execute write-back (NORMAL/MOV/LOAD/NOP)
//             ld_rsv*          reserve a register for an outstanding load
//             ld_ret*          load data return
//             busy_vec         registered scoreboard
//             hazard           combinational RAW hazard indication
//             err              sticky protocol error
//  Revision : 1.0  initial release
// ============================================================================
module mcpu_regfile_sb #(
    parameter int WORD_SIZE         = 16,
    parameter int REGS_NUMBER_WIDTH = 4,
    parameter bit BYPASS            = 1'b1,
    parameter bit ZERO_REG          = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REGS_NUMBER_WIDTH-1:0]  op1,
    input  logic [REGS_NUMBER_WIDTH-1:0]  op2,
    input  logic [REGS_NUMBER_WIDTH-1:0]  op3,
    input  logic [2:0]                    rd_use,
    output logic [WORD_SIZE-1:0]          RegOp1,
    output logic [WORD_SIZE-1:0]          alu1,
    output logic [WORD_SIZE-1:0]          alu2,
    input  logic                          wb_en,
    input  logic [1:0]                    wb_cmd,
    input  logic [REGS_NUMBER_WIDTH-1:0]  wb_dst,
    input  logic [REGS_NUMBER_WIDTH-1:0]  wb_src,
    input  logic [WORD_SIZE-1:0]          wb_data,
    input  logic                          ld_rsv,
    input  logic [REGS_NUMBER_WIDTH-1:0]  ld_rsv_dst,
    input  logic                          ld_ret,
    input  logic [REGS_NUMBER_WIDTH-1:0]  ld_ret_dst,
    input  logic [WORD_SIZE-1:0]          ld_ret_data,
    output logic [(1<<REGS_NUMBER_WIDTH)-1:0] busy_vec,
    output logic                          hazard,
    output logic                          err
);

    localparam int REGISTERS_NUMBER = 1 << REGS_NUMBER_WIDTH;
    localparam logic [1:0] CMD_MOV  = 2'b01;
    localparam logic [1:0] CMD_NOP  = 2'b11;

    logic [WORD_SIZE-1:0]        regs_q [REGISTERS_NUMBER];
    logic [WORD_SIZE-1:0]        regs_d [REGISTERS_NUMBER];
    logic [REGISTERS_NUMBER-1:0] busy_q, busy_d;
    logic [REGISTERS_NUMBER-1:0] stale_q, stale_d;
    logic                        err_q, err_d;

    logic                        w_wb_write;
    logic                        w_wb_byp;
    logic [WORD_SIZE-1:0]        w_wb_value;
    logic                        w_ret_valid;
    logic                        w_ret_accept;
    logic                        w_ret_apply;
    logic                        w_rsv_valid;

    // Accesses to R0 vanish entirely when it is hardwired to zero.
    function automatic logic is_r0_blocked(input logic [REGS_NUMBER_WIDTH-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign w_wb_write   = wb_en && (wb_cmd != CMD_NOP) && !is_r0_blocked(wb_dst);
    // Only NORMAL/LOAD data is on a wire this cycle; MOV data comes from the array.
    assign w_wb_byp     = w_wb_write && (wb_cmd != CMD_MOV);
    assign w_wb_value   = (wb_cmd == CMD_MOV) ? regs_q[wb_src] : wb_data;
    assign w_ret_valid  = ld_ret && !is_r0_blocked(ld_ret_dst);
    assign w_ret_accept = w_ret_valid && busy_q[ld_ret_dst];
    // A younger write-back to the same register makes the returning data stale.
    assign w_ret_apply  = w_ret_accept && !stale_q[ld_ret_dst]
                          && !(w_wb_write && (wb_dst == ld_ret_dst));
    assign w_rsv_valid  = ld_rsv && !is_r0_blocked(ld_rsv_dst);

    // Next-state computation: array, scoreboard and error flag.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        stale_d = stale_q;
        err_d   = err_q;

        if (w_ret_apply) begin
            regs_d[ld_ret_dst] = ld_ret_data;
        end
        if (w_wb_write) begin
            regs_d[wb_dst] = w_wb_value;
            if (busy_q[wb_dst]) begin
                stale_d[wb_dst] = 1'b1;
            end
        end
        if (w_ret_valid) begin
            if (busy_q[ld_ret_dst]) begin
                busy_d[ld_ret_dst]  = 1'b0;
                stale_d[ld_ret_dst] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        // Reservation comes last so a same-cycle return+reserve re-arms busy.
        if (w_rsv_valid) begin
            if (busy_q[ld_rsv_dst] && !(w_ret_accept && (ld_ret_dst == ld_rsv_dst))) begin
                err_d = 1'b1;
            end else begin
                busy_d[ld_rsv_dst]  = 1'b1;
                stale_d[ld_rsv_dst] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGISTERS_NUMBER; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            stale_q <= '0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            stale_q <= stale_d;
            err_q   <= err_d;
        end
    end

    // Read ports and hazard detection.
    logic [REGS_NUMBER_WIDTH-1:0] w_rd_addr [3];
    logic [WORD_SIZE-1:0]         w_rd_data [3];
    logic [2:0]                   w_rd_haz;

    assign w_rd_addr[0] = op1;
    assign w_rd_addr[1] = op2;
    assign w_rd_addr[2] = op3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rd_data[p] = regs_q[w_rd_addr[p]];
            w_rd_haz[p]  = rd_use[p] && busy_q[w_rd_addr[p]];
            if (BYPASS) begin
                if (w_wb_byp && (w_rd_addr[p] == wb_dst)) begin
                    w_rd_data[p] = wb_data;
                end else if (w_ret_apply && (w_rd_addr[p] == ld_ret_dst)) begin
                    // The returning load satisfies this operand right now.
                    w_rd_data[p] = ld_ret_data;
                    w_rd_haz[p]  = 1'b0;
                end
            end
            if (is_r0_blocked(w_rd_addr[p])) begin
                w_rd_data[p] = '0;
            end
        end
    end

    assign RegOp1   = w_rd_data[0];
    assign alu1     = w_rd_data[1];
    assign alu2     = w_rd_data[2];
    assign hazard   = |w_rd_haz;
    assign busy_vec = busy_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcpu_regfile_sb
//  Purpose  : Self-checking bench for mcpu_regfile_sb. Two instances share
//             the stimulus: A (bypass, normal R0) and B (no bypass, zero R0).
//             Outputs are compared against a behavioural register-file model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcpu_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op1, op2, op3;
    logic [2:0]  rd_use;
    logic        wb_en;
    logic [1:0]  wb_cmd;
    logic [3:0]  wb_dst, wb_src;
    logic [15:0] wb_data;
    logic        ld_rsv;
    logic [3:0]  ld_rsv_dst;
    logic        ld_ret;
    logic [3:0]  ld_ret_dst;
    logic [15:0] ld_ret_data;

    logic [15:0] a_op1, a_alu1, a_alu2, a_busy;
    logic        a_haz, a_err;
    logic [15:0] b_op1, b_alu1, b_alu2, b_busy;
    logic        b_haz, b_err;

    always #5 clk = ~clk;

    mcpu_regfile_sb #(.WORD_SIZE(16), .REGS_NUMBER_WIDTH(4), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .op3(op3), .rd_use(rd_use),
        .RegOp1(a_op1), .alu1(a_alu1), .alu2(a_alu2),
        .wb_en(wb_en), .wb_cmd(wb_cmd), .wb_dst(wb_dst), .wb_src(wb_src), .wb_data(wb_data),
        .ld_rsv(ld_rsv), .ld_rsv_dst(ld_rsv_dst),
        .ld_ret(ld_ret), .ld_ret_dst(ld_ret_dst), .ld_ret_data(ld_ret_data),
        .busy_vec(a_busy), .hazard(a_haz), .err(a_err)
    );

    mcpu_regfile_sb #(.WORD_SIZE(16), .REGS_NUMBER_WIDTH(4), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst(rst), .op1(op1), .op2(op2), .op3(op3), .rd_use(rd_use),
        .RegOp1(b_op1), .alu1(b_alu1), .alu2(b_alu2),
        .wb_en(wb_en), .wb_cmd(wb_cmd), .wb_dst(wb_dst), .wb_src(wb_src), .wb_data(wb_data),
        .ld_rsv(ld_rsv), .ld_rsv_dst(ld_rsv_dst),
        .ld_ret(ld_ret), .ld_ret_dst(ld_ret_dst), .ld_ret_data(ld_ret_data),
        .busy_vec(b_busy), .hazard(b_haz), .err(b_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_reg   [2][16];
    bit          m_busy  [2][16];
    bit          m_stale [2][16];
    bit          m_err   [2];
    bit          m_byp   [2] = '{1'b1, 1'b0};
    bit          m_zero  [2] = '{1'b0, 1'b1};
    bit          m_init  = 1'b0;

    function automatic bit gone(int k, logic [3:0] a);
        return m_zero[k] && (a == 4'd0);
    endfunction

    function automatic bit wb_writes(int k);
        return wb_en && (wb_cmd != 2'b11) && !gone(k, wb_dst);
    endfunction

    // Load data that actually lands in the register this cycle.
    function automatic bit ret_lands(int k);
        return ld_ret && !gone(k, ld_ret_dst) && m_busy[k][ld_ret_dst]
               && !m_stale[k][ld_ret_dst] && !(wb_writes(k) && wb_dst == ld_ret_dst);
    endfunction

    function automatic logic [15:0] exp_read(int k, logic [3:0] a);
        if (gone(k, a)) return 16'h0;
        if (m_byp[k]) begin
            if (wb_writes(k) && wb_cmd != 2'b01 && wb_dst == a) return wb_data;
            if (ret_lands(k) && ld_ret_dst == a) return ld_ret_data;
        end
        return m_reg[k][a];
    endfunction

    function automatic logic exp_hazard(int k);
        logic [3:0] ops [3];
        ops[0] = op1; ops[1] = op2; ops[2] = op3;
        for (int p = 0; p < 3; p++) begin
            if (rd_use[p] && m_busy[k][ops[p]]) begin
                if (!(m_byp[k] && ret_lands(k) && ld_ret_dst == ops[p]
                      && !(wb_writes(k) && wb_cmd != 2'b01 && wb_dst == ops[p])))
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_busy(int k);
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = m_busy[k][r];
        return v;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] old_reg [16];
            bit old_busy [16];
            bit lands, accepted;
            old_reg  = m_reg[k];
            old_busy = m_busy[k];
            if (rst) begin
                for (int r = 0; r < 16; r++) begin
                    m_reg[k][r] = 16'h0; m_busy[k][r] = 1'b0; m_stale[k][r] = 1'b0;
                end
                m_err[k] = 1'b0;
                continue;
            end
            lands    = ret_lands(k);
            accepted = ld_ret && !gone(k, ld_ret_dst) && old_busy[ld_ret_dst];
            if (lands) m_reg[k][ld_ret_dst] = ld_ret_data;
            if (wb_writes(k)) begin
                m_reg[k][wb_dst] = (wb_cmd == 2'b01) ? old_reg[wb_src] : wb_data;
                if (old_busy[wb_dst]) m_stale[k][wb_dst] = 1'b1;
            end
            if (ld_ret && !gone(k, ld_ret_dst)) begin
                if (accepted) begin
                    m_busy[k][ld_ret_dst] = 1'b0; m_stale[k][ld_ret_dst] = 1'b0;
                end else m_err[k] = 1'b1;
            end
            if (ld_rsv && !gone(k, ld_rsv_dst)) begin
                if (old_busy[ld_rsv_dst] && !(accepted && ld_ret_dst == ld_rsv_dst)) m_err[k] = 1'b1;
                else begin
                    m_busy[k][ld_rsv_dst] = 1'b1; m_stale[k][ld_rsv_dst] = 1'b0;
                end
            end
        end
        m_init = 1'b1;
    endtask

    // ---------------- cycle helpers ----------------
    task automatic settle();
        #1;
        if (m_init) begin
            check_val("a_RegOp1", a_op1,  exp_read(0, op1));
            check_val("a_alu1",   a_alu1, exp_read(0, op2));
            check_val("a_alu2",   a_alu2, exp_read(0, op3));
            check_val("a_hazard", a_haz,  exp_hazard(0));
            check_val("b_RegOp1", b_op1,  exp_read(1, op1));
            check_val("b_alu1",   b_alu1, exp_read(1, op2));
            check_val("b_alu2",   b_alu2, exp_read(1, op3));
            check_val("b_hazard", b_haz,  exp_hazard(1));
        end
    endtask

    task automatic clock();
        @(posedge clk);
        model_edge();
        #1;
        check_val("a_busy_vec", a_busy, exp_busy(0));
        check_val("a_err",      a_err,  m_err[0]);
        check_val("b_busy_vec", b_busy, exp_busy(1));
        check_val("b_err",      b_err,  m_err[1]);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; op1 = 4'd0; op2 = 4'd0; op3 = 4'd0; rd_use = 3'b000;
        wb_en = 1'b0; wb_cmd = 2'b11; wb_dst = 4'd0; wb_src = 4'd0; wb_data = 16'h0;
        ld_rsv = 1'b0; ld_rsv_dst = 4'd0; ld_ret = 1'b0; ld_ret_dst = 4'd0; ld_ret_data = 16'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        settle();
        clock();

        // Reset state: every register reads zero through all ports.
        idle();
        for (int a = 0; a < 16; a += 3) begin
            op1 = 4'(a); op2 = 4'(a + 1); op3 = 4'(a + 2); rd_use = 3'b111;
            settle();
            check_val("rst_read", a_op1 | a_alu1 | a_alu2, 32'h0);
            check_val("rst_hazard", a_haz, 1'b0);
            clock();
        end
        check_val("rst_busy", a_busy, 16'h0);

        // Normal write with same-cycle read.
        idle();
        wb_en = 1'b1; wb_cmd = 2'b00; wb_dst = 4'd3; wb_data = 16'hBEEF; op2 = 4'd3;
        settle();
        check_val("byp_wb_a", a_alu1, 16'hBEEF);
        check_val("byp_wb_b", b_alu1, 16'h0000);
        clock();
        idle(); op2 = 4'd3;
        settle();
        check_val("wb_vis_b", b_alu1, 16'hBEEF);
        clock();

        // MOV R5 <= R3: not bypassed, visible next cycle.
        idle();
        wb_en = 1'b1; wb_cmd = 2'b01; wb_dst = 4'd5; wb_src = 4'd3; op1 = 4'd5;
        settle();
        check_val("mov_old", a_op1, 16'h0000);
        clock();
        idle(); op1 = 4'd5;
        settle();
        check_val("mov_new", a_op1, 16'hBEEF);
        clock();

        // Load reservation, hazard, bypassed return.
        idle(); ld_rsv = 1'b1; ld_rsv_dst = 4'd7;
        settle(); clock();
        idle(); op3 = 4'd7; rd_use = 3'b100;
        settle();
        check_val("haz_busy", a_haz, 1'b1);
        clock();
        idle(); op3 = 4'd7; rd_use = 3'b100; ld_ret = 1'b1; ld_ret_dst = 4'd7; ld_ret_data = 16'h1234;
        settle();
        check_val("ret_byp", a_alu2, 16'h1234);
        check_val("ret_haz", a_haz, 1'b0);
        clock();
        check_val("ret_busy7", a_busy[7], 1'b0);

        // Younger write-back beats a returning load.
        idle(); ld_rsv = 1'b1; ld_rsv_dst = 4'd2;
        settle(); clock();
        idle(); wb_en = 1'b1; wb_cmd = 2'b00; wb_dst = 4'd2; wb_data = 16'h0055;
        settle(); clock();
        idle(); ld_ret = 1'b1; ld_ret_dst = 4'd2; ld_ret_data = 16'hAAAA;
        settle(); clock();
        idle(); op1 = 4'd2;
        settle();
        check_val("stale_keep", a_op1, 16'h0055);
        check_val("stale_err", a_err, 1'b0);
        clock();

        // Return to a non-busy register, reservation of R0.
        idle(); ld_ret = 1'b1; ld_ret_dst = 4'd9; ld_ret_data = 16'h7777;
        settle(); clock();
        check_val("err_set", a_err, 1'b1);
        idle(); ld_rsv = 1'b1; ld_rsv_dst = 4'd0; op1 = 4'd0;
        settle(); clock();
        check_val("r0_busy_b", b_busy[0], 1'b0);
        check_val("err_sticky", a_err, 1'b1);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            int nb;
            logic [3:0] bl [16];
            idle();
            nb = 0;
            for (int r = 0; r < 16; r++) if (m_busy[0][r]) begin bl[nb] = 4'(r); nb++; end
            rst         = ($urandom_range(99) < 2);
            op1         = 4'($urandom); op2 = 4'($urandom); op3 = 4'($urandom);
            rd_use      = 3'($urandom);
            wb_en       = ($urandom_range(99) < 50);
            wb_cmd      = 2'($urandom);
            wb_dst      = 4'($urandom); wb_src = 4'($urandom);
            wb_data     = 16'($urandom);
            ld_rsv      = ($urandom_range(99) < 35);
            ld_rsv_dst  = 4'($urandom);
            ld_ret      = ($urandom_range(99) < 40);
            ld_ret_dst  = (nb > 0 && $urandom_range(99) < 80) ? bl[$urandom_range(nb - 1)] : 4'($urandom);
            ld_ret_data = 16'($urandom);
            if ($urandom_range(99) < 25) op3 = ld_ret_dst;
            if ($urandom_range(99) < 25) op2 = wb_dst;
            settle();
            clock();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
